// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl: sole Avalon-MM master on the switch PIO. It polls the PIO on a
// fixed interval, debounces each sample over consecutive identical reads, and latches
// changed bits into a maskable edge-capture register that drives a level interrupt.
// The CPU reaches it through a 4-word slave: state, mask, edge (W1C), ctrl/status.
//
// CPU slave transfer semantics: a read or write transfer happens in any cycle where
// s_read or s_write is high. There are no wait states. Write data is taken on that
// clock edge. Read data for the addressed word appears on s_readdata in the
// following cycle and holds there until the next read. A read and a write to the
// same word in one cycle returns the value from before the write.
module switch_poll_ctrl #(
  parameter int WIDTH      = 8,
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       pio_address,
  input  logic [31:0]      pio_readdata,
  input  logic [1:0]       s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  output logic             irq,
  output logic [WIDTH-1:0] sw_state,
  output logic [1:0]       dbg_state
);

  // Divider width covers the reload value POLL_DIV-1 (POLL_DIV is at least 4).
  localparam int               DIV_W      = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(POLL_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [3:0]       CNT_MAX    = 4'(STABLE_CNT);

  // Poll sequencer states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  // CPU register word addresses.
  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_EDGE  = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // PIO word addresses: 0 is the switch data, 1 is a location that reads zero.
  localparam logic [1:0] PIO_DATA = 2'b00;
  localparam logic [1:0] PIO_IDLE = 2'b01;

  // Sequencer and divider.
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             poll_start;
  logic             in_update;
  logic             busy;

  // Sampling and debounce.
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] last_raw_q, last_raw_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_state_q, sw_state_d;
  logic [3:0]       cnt_upd;
  logic [WIDTH-1:0] last_upd;
  logic             commit;

  // CPU-visible registers.
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             enable_q, enable_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      status_word;
  logic             wr_mask;
  logic             wr_edge;
  logic             wr_ctrl;

  // Upper PIO bits and unused write-data bits carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{pio_readdata[31:WIDTH], s_writedata[31:WIDTH]};

  assign poll_start = (state_q == ST_IDLE) && enable_q && (div_q == '0);
  assign in_update  = (state_q == ST_UPDATE);
  assign busy       = (state_q != ST_IDLE);

  assign wr_mask = s_write && (s_address == REG_MASK);
  assign wr_edge = s_write && (s_address == REG_EDGE);
  assign wr_ctrl = s_write && (s_address == REG_CTRL);

  // Next poll state: a poll is a fixed ADDR -> SAMPLE -> UPDATE walk once started,
  // so clearing enable mid-poll still lets it finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (poll_start) state_d = ST_ADDR;
      ST_ADDR:   state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Poll interval divider: parked at the reload value while disabled, reloaded at
  // each poll start, otherwise counting down to zero.
  always_comb begin
    div_d = div_q;
    if (!enable_q) begin
      div_d = DIV_RELOAD;
    end else if (poll_start) begin
      div_d = DIV_RELOAD;
    end else if (div_q != '0) begin
      div_d = div_q - DIV_ONE;
    end
  end

  // Capture the PIO word at the end of SAMPLE; the PIO registers its data, so the
  // word addressed during ADDR is on readdata during SAMPLE.
  always_comb begin
    raw_d = raw_q;
    if (state_q == ST_SAMPLE) begin
      raw_d = pio_readdata[WIDTH-1:0];
    end
  end

  // Debounce arithmetic for the UPDATE cycle: run length of identical samples
  // saturating at STABLE_CNT, and whether the stable value differs from sw_state.
  always_comb begin
    if (raw_q == last_raw_q) begin
      cnt_upd  = (cnt_q >= CNT_MAX) ? CNT_MAX : (cnt_q + 4'd1);
      last_upd = last_raw_q;
    end else begin
      cnt_upd  = 4'd1;
      last_upd = raw_q;
    end
    commit = (cnt_upd == CNT_MAX) && (last_upd != sw_state_q);
  end

  // Apply the debounce result only in UPDATE; changed bits are reported as edges.
  always_comb begin
    last_raw_d = last_raw_q;
    cnt_d      = cnt_q;
    sw_state_d = sw_state_q;
    edge_set   = '0;
    if (in_update) begin
      last_raw_d = last_upd;
      cnt_d      = cnt_upd;
      if (commit) begin
        sw_state_d = last_upd;
        edge_set   = sw_state_q ^ last_upd;
      end
    end
  end

  // Edge capture with write-1-to-clear; a bit being set this cycle beats a clear.
  always_comb begin
    edge_clr = wr_edge ? s_writedata[WIDTH-1:0] : '0;
    edge_d   = (edge_q & ~edge_clr) | edge_set;
  end

  // Writable CPU registers; writes to read-only words and bits are dropped.
  always_comb begin
    mask_d   = wr_mask ? s_writedata[WIDTH-1:0] : mask_q;
    enable_d = wr_ctrl ? s_writedata[0] : enable_q;
  end

  // Registered read mux: reads current register values, so a same-cycle write to
  // the same word is not yet visible, and reads have no side effects.
  always_comb begin
    status_word = {24'd0, cnt_q, 2'b00, busy, enable_q};
    rdata_d     = rdata_q;
    if (s_read) begin
      unique case (s_address)
        REG_STATE: rdata_d = 32'(sw_state_q);
        REG_MASK:  rdata_d = 32'(mask_q);
        REG_EDGE:  rdata_d = 32'(edge_q);
        REG_CTRL:  rdata_d = status_word;
        default:   rdata_d = '0;
      endcase
    end
  end

  // Sequencer and divider registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_RELOAD;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  // Sample and debounce registers; a reset mid-poll discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q      <= '0;
      last_raw_q <= '0;
      cnt_q      <= '0;
      sw_state_q <= '0;
    end else begin
      raw_q      <= raw_d;
      last_raw_q <= last_raw_d;
      cnt_q      <= cnt_d;
      sw_state_q <= sw_state_d;
    end
  end

  // CPU-visible registers and the registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q   <= '0;
      mask_q   <= '0;
      enable_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      enable_q <= enable_d;
      rdata_q  <= rdata_d;
    end
  end

  assign pio_address = ((state_q == ST_ADDR) || (state_q == ST_SAMPLE)) ? PIO_DATA : PIO_IDLE;
  assign irq         = |(edge_q & mask_q);
  assign sw_state    = sw_state_q;
  assign s_readdata  = rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// Bench for switch_poll_ctrl with a short poll interval: a registered PIO model,
// a table of per-poll vectors, hand sequences for interrupt / collision / enable /
// reset corners, and a random phase checked against a sample-history model.
module tb_switch_poll_ctrl;

  localparam int P = 8;
  localparam int S = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;
  logic [7:0]  sw_state;
  logic [1:0]  dbg_state;
  logic [7:0]  in_port;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Switch PIO: registered readdata, switch bits at word 0, zero elsewhere.
  always @(posedge clk) pio_readdata <= (pio_address == 2'b00) ? {24'd0, in_port} : 32'd0;

  switch_poll_ctrl #(.WIDTH(8), .POLL_DIV(P), .STABLE_CNT(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata),
    .s_address    (s_address),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .irq          (irq),
    .sw_state     (sw_state),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int last_start = -1;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    tick(1);
    s_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    tick(1);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic cpu_rw(input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
    s_address = a; s_writedata = d; s_write = 1'b1; s_read = 1'b1;
    tick(1);
    s_write = 1'b0; s_read = 1'b0;
    q = s_readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Count cycles until pio_address goes to 0; the bound turns a missing poll into a FAIL.
  task automatic wait_poll(output int n);
    n = 0;
    while (pio_address != 2'b00 && n < 3 * P) begin
      tick(1);
      n++;
    end
    chk("poll_start_seen", pio_address, 2'b00);
  endtask

  // One complete poll: checks start timing and the two-cycle PIO access, optionally
  // issues an edge W1C during the UPDATE cycle; returns one cycle after UPDATE.
  task automatic run_poll(input bit first, input logic [7:0] upd_clr);
    int n;
    wait_poll(n);
    if (first) chk("first_poll_delay", n, P);
    else       chk("poll_period", cyc - last_start, P);
    last_start = cyc;
    tick(1);
    chk("pio_addr_sample", pio_address, 2'b00);
    tick(1);
    chk("pio_addr_update", pio_address, 2'b01);
    if (upd_clr != 8'h00) cpu_write(2'd2, {24'd0, upd_clr});
    else                  tick(1);
  endtask

  task automatic count_idle(input string name, input int cycles);
    int z = 0;
    for (int k = 0; k < cycles; k++) begin
      tick(1);
      if (pio_address == 2'b00) z++;
    end
    chk(name, z, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] in_val;
    bit         rst_before;
    logic [7:0] exp_state;
    logic [7:0] exp_edge;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic [7:0]  mask_v, m_state, m_edge, clr, nxt;
    logic [7:0]  hist[$];
    int          run, r, n;

    // basic poll from reset, then saturation of the stable count
    vecs[0]  = '{8'h5A, 1'b1, 8'h00, 8'h00, 4'd1};
    vecs[1]  = '{8'h5A, 1'b0, 8'h00, 8'h00, 4'd2};
    vecs[2]  = '{8'h5A, 1'b0, 8'h5A, 8'h5A, 4'd3};
    vecs[3]  = '{8'h5A, 1'b0, 8'h5A, 8'h5A, 4'd3};
    // bounce rejection from reset: 01,00,01,01,01
    vecs[4]  = '{8'h01, 1'b1, 8'h00, 8'h00, 4'd1};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 8'h00, 4'd1};
    vecs[6]  = '{8'h01, 1'b0, 8'h00, 8'h00, 4'd1};
    vecs[7]  = '{8'h01, 1'b0, 8'h00, 8'h00, 4'd2};
    vecs[8]  = '{8'h01, 1'b0, 8'h01, 8'h01, 4'd3};
    // second change accumulates into edge
    vecs[9]  = '{8'h03, 1'b0, 8'h01, 8'h01, 4'd1};
    vecs[10] = '{8'h03, 1'b0, 8'h01, 8'h01, 4'd2};
    vecs[11] = '{8'h03, 1'b0, 8'h03, 8'h03, 4'd3};

    reset = 1'b1; s_address = 2'd0; s_read = 1'b0; s_write = 1'b0;
    s_writedata = 32'd0; in_port = 8'hFF;

    // ---- reset behaviour ----
    tick(3);
    chk("rst_sw_state", sw_state, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_readdata", s_readdata, 32'd0);
    chk("rst_pio_address", pio_address, 2'b01);
    reset = 1'b0;
    count_idle("rst_no_poll_disabled", 3 * P);
    cpu_read(2'd1, rd); chk("rst_mask", rd, 32'd0);
    cpu_read(2'd3, rd); chk("rst_ctrl", rd, 32'd0);

    // ---- table-driven polls ----
    for (int i = 0; i < 12; i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].rst_before) begin
        do_reset();
        cpu_write(2'd3, 32'd1);
        run_poll(1'b1, 8'h00);
      end else begin
        run_poll(1'b0, 8'h00);
      end
      chk($sformatf("vec%0d_sw_state", i), sw_state, vecs[i].exp_state);
      cpu_read(2'd2, rd); chk($sformatf("vec%0d_edge", i), rd, vecs[i].exp_edge);
      cpu_read(2'd3, rd); chk($sformatf("vec%0d_ctrl", i), rd, {24'd0, vecs[i].exp_cnt, 4'b0001});
    end

    // ---- interrupt path ----
    in_port = 8'hF0;
    do_reset();
    cpu_write(2'd1, 32'h0F);
    cpu_write(2'd3, 32'd1);
    run_poll(1'b1, 8'h00); run_poll(1'b0, 8'h00); run_poll(1'b0, 8'h00);
    chk("irq_sw_f0", sw_state, 8'hF0);
    cpu_read(2'd2, rd); chk("irq_edge_f0", rd, 32'hF0);
    chk("irq_masked_off", irq, 1'b0);
    in_port = 8'hF1;
    run_poll(1'b0, 8'h00); run_poll(1'b0, 8'h00); run_poll(1'b0, 8'h00);
    chk("irq_rise", irq, 1'b1);
    chk("irq_sw_f1", sw_state, 8'hF1);
    cpu_read(2'd2, rd); chk("irq_edge_f1", rd, 32'hF1);
    cpu_write(2'd2, 32'h01);
    chk("irq_fall_after_w1c", irq, 1'b0);
    cpu_read(2'd2, rd); chk("irq_edge_after_w1c", rd, 32'hF0);

    // ---- W1C colliding with an UPDATE that sets the same bit ----
    in_port = 8'hF0;
    run_poll(1'b0, 8'h00); run_poll(1'b0, 8'h00); run_poll(1'b0, 8'h01);
    chk("coll_sw", sw_state, 8'hF0);
    cpu_read(2'd2, rd); chk("coll_edge_set_wins", rd, 32'hF1);
    chk("coll_irq", irq, 1'b1);
    cpu_read(2'd3, rd); chk("coll_ctrl", rd, 32'h31);
    cpu_write(2'd0, 32'hFF);
    cpu_read(2'd0, rd); chk("ro_state_write_ignored", rd, 32'hF0);

    // ---- clear enable during SAMPLE ----
    in_port = 8'hF2;
    run_poll(1'b0, 8'h00); run_poll(1'b0, 8'h00);
    wait_poll(n);
    chk("dis_poll_period", cyc - last_start, P);
    tick(1);
    cpu_write(2'd3, 32'd0);
    chk("dis_pio_update", pio_address, 2'b01);
    tick(1);
    chk("dis_poll_completed", sw_state, 8'hF2);
    cpu_read(2'd2, rd); chk("dis_edge", rd, 32'hF3);
    count_idle("dis_no_more_polls", 4 * P);
    cpu_read(2'd3, rd); chk("dis_ctrl", rd, 32'h30);
    cpu_rw(2'd1, 32'h3C, rd); chk("rw_returns_old_mask", rd, 32'h0F);
    cpu_read(2'd1, rd); chk("rw_new_mask", rd, 32'h3C);

    // ---- reset during ADDR ----
    cpu_write(2'd3, 32'd1);
    wait_poll(n);
    chk("addr_rst_first_delay", n, P);
    reset = 1'b1;
    tick(1);
    chk("addr_rst_pio", pio_address, 2'b01);
    chk("addr_rst_sw", sw_state, 8'h00);
    chk("addr_rst_irq", irq, 1'b0);
    chk("addr_rst_readdata", s_readdata, 32'd0);
    reset = 1'b0;
    cpu_read(2'd3, rd); chk("addr_rst_ctrl", rd, 32'd0);
    count_idle("addr_rst_no_poll", 2 * P);

    // ---- random polls against the sample-history model ----
    do_reset();
    mask_v = 8'($urandom_range(1, 255));
    cpu_write(2'd1, {24'd0, mask_v});
    m_state = 8'h00; m_edge = 8'h00;
    in_port = 8'($urandom_range(0, 255));
    cpu_write(2'd3, 32'd1);
    for (int p = 0; p < 40; p++) begin
      if (p > 0) begin
        r = $urandom_range(0, 9);
        if (r >= 6 && r < 9) begin
          nxt = in_port ^ (8'h01 << $urandom_range(0, 7));
          in_port = nxt;
        end else if (r == 9) begin
          in_port = 8'($urandom_range(0, 255));
        end
      end
      run_poll(p == 0, 8'h00);
      hist.push_back(in_port);
      run = 0;
      for (int k = hist.size() - 1; k >= 0; k--) begin
        if (hist[k] != in_port) break;
        run++;
      end
      if (run >= S && in_port != m_state) begin
        m_edge  = m_edge | (in_port ^ m_state);
        m_state = in_port;
      end
      exp_q.push_back(m_state);
      chk($sformatf("rnd%0d_sw_state", p), sw_state, exp_q.pop_front());
      chk($sformatf("rnd%0d_irq", p), irq, |(m_edge & mask_v));
      if ($urandom_range(0, 3) == 0) begin
        clr = 8'($urandom_range(0, 255));
        cpu_write(2'd2, {24'd0, clr});
        m_edge = m_edge & ~clr;
      end
      cpu_read(2'd2, rd); chk($sformatf("rnd%0d_edge", p), rd, {24'd0, m_edge});
      chk($sformatf("rnd%0d_irq_after", p), irq, |(m_edge & mask_v));
      cpu_read(2'd3, rd);
      chk($sformatf("rnd%0d_ctrl", p), rd, {24'd0, 4'((run > S) ? S : run), 4'b0001});
    end

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_poll_ctrl.md
# switch_poll_ctrl

Polling controller for the 8-bit switch PIO input port. It acts as the sole Avalon-MM master on the PIO slave and reads it on a fixed programmable interval. Each read result is debounced over consecutive identical samples, and bit changes are latched into a maskable edge-capture register that drives an interrupt to the Nios II CPU. The CPU reaches the controller through its own 4-word Avalon-MM slave and no longer polls the PIO directly.

## Interface
Parameters:
- WIDTH, 8: number of switch bits taken from PIO readdata[WIDTH-1:0].
- POLL_DIV, 50000: clock cycles between poll starts; legal range is 4 or more.
- STABLE_CNT, 4: number of consecutive identical samples required before the debounced state changes; legal range is 1 to 15.

Ports:
- clk, input, 1: system clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- pio_address, output, 2: address to the switch PIO slave.
- pio_readdata, input, 32: PIO readdata; registered in the PIO, one-cycle latency after the address is presented.
- s_address, input, 2: CPU slave word address.
- s_read, input, 1: CPU read strobe.
- s_write, input, 1: CPU write strobe.
- s_writedata, input, 32: CPU write data.
- s_readdata, output, 32: CPU read data; registered.
- irq, output, 1: level interrupt, equal to |(edge & mask).
- sw_state, output, WIDTH: debounced switch state, also available to fabric logic.

## Operation
- Register map (word address):
  - 0: debounced state, read-only.
  - 1: irq mask, read/write.
  - 2: edge capture; write-1-to-clear.
  - 3: ctrl/status. bit0 = enable (R/W). bit1 = busy (RO, 1 when FSM is not in IDLE). bits[7:4] = current stable count (RO). All other bits read 0.
  - Writes to read-only bits are ignored.
- FSM states: IDLE, ADDR, SAMPLE, UPDATE.
  - IDLE → ADDR when div counter == 0 and enable == 1.
  - ADDR → SAMPLE unconditionally.
  - SAMPLE → UPDATE unconditionally.
  - UPDATE → IDLE unconditionally.
- pio_address is 2'b00 in ADDR and SAMPLE, and 2'b01 (reads zero) in all other states.
- At the end of SAMPLE, raw = pio_readdata[WIDTH-1:0].
- UPDATE debounce logic:
  - If raw == last_raw, cnt = min(cnt+1, STABLE_CNT).
  - Otherwise cnt = 1 and last_raw = raw.
  - If the resulting cnt == STABLE_CNT and last_raw != sw_state, then sw_state <= last_raw and edge <= edge | (sw_state ^ last_raw).
- Div counter:
  - Loads POLL_DIV-1 on entry to ADDR.
  - Decrements every cycle while enabled and nonzero.
  - Is held at POLL_DIV-1 while enable == 0.
- Clearing enable:
  - An in-flight poll completes through UPDATE.
  - No new poll starts.
- Edge write-clear: edge <= (edge & ~s_writedata) | set_bits_this_cycle. When a set and a clear hit the same bit in the same cycle, the set wins.
- Register reads:
  - s_readdata updates one cycle after s_read with the addressed word, zero-extended.
  - s_readdata holds its value when s_read == 0.
  - Reads have no side effects.
- Simultaneous s_read and s_write to the same address returns the pre-write value.

## Timing
- Reset values:
  - sw_state, last_raw, cnt, edge, mask, enable, s_readdata, irq: 0.
  - pio_address: 2'b01.
  - FSM: IDLE.
  - Div counter: POLL_DIV-1.
- Reset asserted mid-poll returns everything to the reset values on the next edge. No partial update survives.
- Poll period is exactly POLL_DIV cycles while enabled.
- The first poll after enable is set starts POLL_DIV cycles after the write cycle.
- Latency from the PIO sample edge to sw_state/edge update is 1 cycle (end of UPDATE).
- irq is combinational from the edge and mask registers. It rises in the cycle after the edge bit sets and falls in the cycle after a clearing write.
- Minimum time for a stable input change to reach sw_state is (STABLE_CNT-1)·POLL_DIV + 3 cycles from the first poll that sees the new value.

## Test plan
- Reset behaviour: hold reset 3 cycles with in_port=0xFF → sw_state=0, irq=0, s_readdata=0, pio_address=2'b01, and no poll starts while enable=0.
- Basic poll (POLL_DIV=8, STABLE_CNT=3): write ctrl=1, hold in_port=0x5A → pio_address=0 for 2 cycles every 8 cycles; sw_state=0x5A after the 3rd poll; reg2 reads 0x5A.
- Bounce rejection: in_port pattern 0x01, 0x00, 0x01, 0x01, 0x01 on successive polls → sw_state stays 0x00 until the 5th poll, then becomes 0x01; edge=0x01.
- Interrupt path: mask=0x0F, set edge bits 0xF0 → irq=0; then cause edge 0x01 → irq=1; then W1C write 0x01 to reg2 → irq=0 next cycle and edge=0xF0.
- Write-clear collision: issue a W1C of 0x01 in the same cycle that UPDATE sets bit0 → edge bit0 remains 1.
- Control corner cases:
  - Clear enable during SAMPLE → the poll completes and no further pio_address=0 cycles occur.
  - Assert reset during ADDR → FSM goes to IDLE, sw_state=0, pio_address=2'b01 next cycle.
